mealy_mod_counter: RTL and testbench

Parametrised modulo-N up/down counter with Mealy-style decode outputs, generalising the team's fixed 2-bit Mealy FSM counter. It adds a configurable width, modulus and match value, plus enable, direction, synchronous load and three end-of-range modes (wrap, saturate, one-shot). It sits beside control FSMs as a reusable event/terminal-count source.

---
 rtl/mealy_cnt_pkg.sv | 25 ++
 rtl/mealy_mod_counter.sv | 92 +++++++++
 tb/tb_mealy_mod_counter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mealy_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mealy_cnt_pkg
// Description : Shared encodings for the modulo-N Mealy counter: end-of-range
//               mode select and control FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
package mealy_cnt_pkg;

    // End-of-range behaviour; the unused code 2'b11 behaves like wrap.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // Control FSM: DONE is only entered from one-shot mode.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage : mealy_cnt_pkg
`default_nettype wire

// File: rtl/mealy_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mealy_mod_counter
// Description : Parametrised modulo-N up/down counter with load, enable,
//               wrap/saturate/one-shot end-of-range modes and Mealy decode
//               outputs (match, terminal count).
// Revision    : 1.0 - initial release
// ============================================================================
module mealy_mod_counter
    import mealy_cnt_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 10,
    parameter longint MATCH   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             tc,
    output logic             done
);

    // Highest legal count; all-ones when MODULUS == 2**WIDTH, so the clamp
    // never fires and wrap is the natural overflow.
    localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MATCH_VAL = WIDTH'(MATCH);

    // Reject illegal parameter sets at elaboration.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "mealy_mod_counter: WIDTH must be in 2..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $fatal(1, "mealy_mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (MATCH < 0 || MATCH >= MODULUS) begin : g_bad_match
        $fatal(1, "mealy_mod_counter: MATCH must be < MODULUS");
    end

    logic [WIDTH-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             at_end;
    logic             running;

    // End of range depends on the direction sampled this cycle.
    assign at_end  = up_dn ? (count_q == MAX_CNT) : (count_q == '0);
    assign running = en && (state_q == ST_RUN);

    // Next-state logic: load beats counting, counting beats hold.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (load) begin
            count_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
            state_d = ST_RUN;
        end else if (running) begin
            if (!at_end) begin
                count_d = up_dn ? (count_q + 1'b1) : (count_q - 1'b1);
            end else begin
                case (mode_e'(mode))
                    MODE_SAT:     count_d = count_q;
                    MODE_ONESHOT: state_d = ST_DONE;
                    default:      count_d = up_dn ? '0 : MAX_CNT;
                endcase
            end
        end
    end

    // State register with asynchronous reset to RUN / zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Mealy decodes are forced low while reset is held.
    assign match = !reset && running && (count_q == MATCH_VAL);
    assign tc    = !reset && running && at_end;
    assign count = count_q;
    assign done  = (state_q == ST_DONE);

endmodule : mealy_mod_counter
`default_nettype wire

// File: tb/tb_mealy_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mealy_mod_counter
// Description : Scoreboard bench for mealy_mod_counter (WIDTH=4, MODULUS=10,
//               MATCH=2): directed scenarios followed by random stimulus,
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_mod_counter;

    localparam int W   = 4;
    localparam int M   = 10;
    localparam int MV  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [1:0]   mode;
    logic [W-1:0] count;
    logic         match;
    logic         tc;
    logic         done;

    mealy_mod_counter #(.WIDTH(W), .MODULUS(M), .MATCH(MV)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .count    (count),
        .match    (match),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit m;
        bit t;
        bit d;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    int m_cnt  = 0;
    bit m_done = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Monitor: pops one expectation per sample request.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            if (q.size() == 0) begin
                check("queue_nonempty", 0, 1);
            end else begin
                e = q.pop_front();
                check("count", int'(count), e.cnt);
                check("match", int'(match), int'(e.m));
                check("tc",    int'(tc),    int'(e.t));
                check("done",  int'(done),  int'(e.d));
            end
        end
    end

    // One cycle of stimulus: drive at negedge, record the outputs expected
    // before the next rising edge, then advance the model across that edge.
    task automatic step(input bit r, input bit e, input bit u, input bit ld,
                        input int lv, input int md);
        exp_t x;
        bit   at_end;
        @(negedge clk);
        reset    = r;
        en       = e;
        up_dn    = u;
        load     = ld;
        load_val = W'(lv);
        mode     = 2'(md);
        if (r) begin
            m_cnt  = 0;
            m_done = 0;
            x = '{0, 0, 0, 0};
        end else begin
            at_end = u ? (m_cnt == M - 1) : (m_cnt == 0);
            x.cnt = m_cnt;
            x.d   = m_done;
            x.m   = e && !m_done && (m_cnt == MV);
            x.t   = e && !m_done && at_end;
            if (ld) begin
                m_cnt  = (lv > M - 1) ? M - 1 : lv;
                m_done = 0;
            end else if (e && !m_done) begin
                if (!at_end)           m_cnt = u ? m_cnt + 1 : m_cnt - 1;
                else if (md == 1)      m_cnt = m_cnt;
                else if (md == 2)      m_done = 1;
                else                   m_cnt = u ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
            end
        end
        q.push_back(x);
        ->sample_ev;
    endtask

    initial begin
        reset = 1'b1; en = 0; up_dn = 1; load = 0; load_val = '0; mode = 2'b00;

        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);

        // Up / wrap: 0..9,0
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 0);

        // Down / wrap from 1: 1,0,9,8
        step(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);

        // Saturate up from 8
        step(0, 0, 1, 1, 8, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);

        // One-shot up from 7 into DONE, en ignored afterwards
        step(0, 0, 1, 1, 7, 2);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 2);
        step(0, 1, 0, 0, 0, 2);
        step(0, 0, 1, 1, 3, 2);
        step(0, 0, 1, 0, 0, 2);
        step(0, 0, 1, 1, 15, 2);
        step(0, 0, 1, 0, 0, 2);

        // Load coinciding with one-shot terminal event
        step(0, 1, 1, 1, 5, 2);
        step(0, 1, 1, 0, 0, 2);

        // Mode 11 behaves like wrap
        step(0, 0, 1, 1, 9, 3);
        step(0, 1, 1, 0, 0, 3);
        step(0, 1, 1, 0, 0, 3);

        // Count to 6 then assert reset between edges
        step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        m_cnt = 0;
        m_done = 0;
        q.push_back('{0, 0, 0, 0});
        ->sample_ev;
        step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 80),
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 8),
                 $urandom_range(0, 15),
                 $urandom_range(0, 3));
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mealy_mod_counter
`default_nettype wire
